// File: rtl/seg_display_arbiter_if.sv
// Bundle of request/pattern inputs and ownership/segment outputs shared between
// the segment-pattern producers and the display arbiter.
interface seg_display_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] seg_in;
    logic [NREQ-1:0]   grant;
    logic [7:0]        seg_out;
    logic              busy;
    logic [7:0]        switch_cnt;

    modport master (
        output req,
        output seg_in,
        input  grant,
        input  seg_out,
        input  busy,
        input  switch_cnt
    );

    modport slave (
        input  req,
        input  seg_in,
        output grant,
        output seg_out,
        output busy,
        output switch_cnt
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of a single seven-segment display: each owner holds it for a
// minimum time, with a one-cycle blank between owners. All outputs registered.
module seg_display_arbiter #(
    parameter int         NREQ        = 4,
    parameter int         HOLD_CYCLES = 1000,
    parameter logic [7:0] IDLE_PAT    = 8'b00000010
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    seg_display_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);
    localparam int TW = $clog2(HOLD_CYCLES);
    localparam logic [TW-1:0] TIMER_MAX = TW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          state_r,      state_nxt_s;
    logic [PW-1:0]   owner_r,      owner_nxt_s;
    logic [NREQ-1:0] grant_r,      grant_nxt_s;
    logic [7:0]      seg_r,        seg_nxt_s;
    logic            busy_r,       busy_nxt_s;
    logic [TW-1:0]   timer_r,      timer_nxt_s;
    logic [PW-1:0]   rr_ptr_r,     rr_ptr_nxt_s;
    logic [7:0]      switch_cnt_r, switch_cnt_nxt_s;

    logic [7:0]      seg_arr_s [NREQ];
    logic [PW-1:0]   win_s;
    logic            any_req_s;
    logic            owner_req_s;
    logic            others_req_s;

    // First requester found scanning ptr, ptr+1, ... modulo NREQ.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] ptr);
        logic found;
        int   idx;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && r[idx]) begin
                rr_pick = PW'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
        ptr_after = PW'((int'(idx) + 1) % NREQ);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
        onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Split the flat pattern bus into per-requester bytes.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            seg_arr_s[i] = bus.seg_in[8*i +: 8];
        end
    end

    assign win_s        = rr_pick(bus.req, rr_ptr_r);
    assign any_req_s    = |bus.req;
    assign owner_req_s  = bus.req[owner_r];
    assign others_req_s = |(bus.req & ~grant_r);

    // Next-state and next-output logic; every register defaults to holding.
    always_comb begin
        state_nxt_s      = state_r;
        owner_nxt_s      = owner_r;
        grant_nxt_s      = grant_r;
        seg_nxt_s        = seg_r;
        busy_nxt_s       = busy_r;
        timer_nxt_s      = timer_r;
        rr_ptr_nxt_s     = rr_ptr_r;
        switch_cnt_nxt_s = switch_cnt_r;
        case (state_r)
            ST_IDLE, ST_GAP: begin
                if (any_req_s) begin
                    state_nxt_s      = ST_SHOW;
                    owner_nxt_s      = win_s;
                    grant_nxt_s      = onehot(win_s);
                    seg_nxt_s        = seg_arr_s[win_s];
                    busy_nxt_s       = 1'b1;
                    timer_nxt_s      = {TW{1'b0}};
                    rr_ptr_nxt_s     = ptr_after(win_s);
                    switch_cnt_nxt_s = switch_cnt_r + 8'd1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = {NREQ{1'b0}};
                    seg_nxt_s   = IDLE_PAT;
                    busy_nxt_s  = 1'b0;
                end
            end
            ST_SHOW: begin
                if (owner_req_s) begin
                    seg_nxt_s = seg_arr_s[owner_r];
                end else begin
                    seg_nxt_s = seg_r;
                end
                if (timer_r == TIMER_MAX) begin
                    timer_nxt_s = timer_r;
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
                // A sole owner still requesting keeps the display past the hold time.
                if ((timer_r == TIMER_MAX) && (!owner_req_s || others_req_s)) begin
                    state_nxt_s = ST_GAP;
                    grant_nxt_s = {NREQ{1'b0}};
                    seg_nxt_s   = 8'h00;
                    busy_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_SHOW;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                owner_nxt_s = {PW{1'b0}};
                grant_nxt_s = {NREQ{1'b0}};
                seg_nxt_s   = IDLE_PAT;
                busy_nxt_s  = 1'b0;
                timer_nxt_s = {TW{1'b0}};
            end
        endcase
    end

    // State and output registers: synchronous reset wins over ena; ena low freezes all.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            owner_r      <= {PW{1'b0}};
            grant_r      <= {NREQ{1'b0}};
            seg_r        <= IDLE_PAT;
            busy_r       <= 1'b0;
            timer_r      <= {TW{1'b0}};
            rr_ptr_r     <= {PW{1'b0}};
            switch_cnt_r <= 8'd0;
        end else if (ena) begin
            state_r      <= state_nxt_s;
            owner_r      <= owner_nxt_s;
            grant_r      <= grant_nxt_s;
            seg_r        <= seg_nxt_s;
            busy_r       <= busy_nxt_s;
            timer_r      <= timer_nxt_s;
            rr_ptr_r     <= rr_ptr_nxt_s;
            switch_cnt_r <= switch_cnt_nxt_s;
        end
    end

    assign bus.grant      = grant_r;
    assign bus.seg_out    = seg_r;
    assign bus.busy       = busy_r;
    assign bus.switch_cnt = switch_cnt_r;
endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Shares a single 8-bit seven-segment display between NREQ requesters, e.g. the sequence-detect status, the digit/test-pattern decoder and debug sources.
- Round-robin arbitration decides ownership; each owner keeps the display for a minimum time so every pattern stays visible.
- A one-cycle blank separates owners.
- Sits between the segment-pattern producers and uo_out.

Parameters:
NREQ, 4, number of requesters (2..8)
HOLD_CYCLES, 1000, minimum cycles an owner keeps the display (>=2)
IDLE_PAT, 8'b00000010, pattern shown when nobody owns the display (middle bar '-')

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
ena  input  1  global enable; low freezes all state and outputs
req  input  NREQ  per-requester display request, level
seg_in  input  8*NREQ  requester i pattern in bits [8i+7:8i]
grant  output  NREQ  one-hot current owner, all-zero when none
seg_out  output  8  registered segment drive
busy  output  1  high in SHOW
switch_cnt  output  8  count of ownership grants, wraps 255->0

Behaviour:
- Reset (rst_n low at posedge clk):
  - state=IDLE, grant=0, seg_out=IDLE_PAT, busy=0.
  - rr_ptr=0, hold timer=0, switch_cnt=0.
  - Reset overrides ena.
  - Reset mid-SHOW drops the grant on the next edge with no GAP cycle.
- ena low: state, timer, rr_ptr, grant, seg_out and switch_cnt all hold.
- All outputs are registered. No combinational path from req to grant.
- Arbitration:
  - Winner is the first index with req high, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - On grant: rr_ptr <= winner+1 mod NREQ; switch_cnt increments.
- States:
  - IDLE:
    - seg_out=IDLE_PAT, grant=0.
    - If any req at edge t: SHOW from t+1, with grant=winner, timer=0, seg_out=seg_in[winner] sampled at t.
  - SHOW:
    - While the owner's req is high, seg_out <= owner's seg_in each cycle (1-cycle latency).
    - If the owner's req drops, seg_out freezes at its last value.
    - The timer increments and saturates at HOLD_CYCLES-1.
    - Release when timer==HOLD_CYCLES-1 AND (owner req low OR any other req high). Next state is GAP.
    - Otherwise stay in SHOW. A sole requester with req high keeps ownership indefinitely, and switch_cnt does not increment.
  - GAP (exactly 1 cycle):
    - grant=0, seg_out=8'h00, busy=0.
    - If any req high, arbitrate and go to SHOW. Else go to IDLE.
- Boundaries:
  - Simultaneous requests resolve by rr_ptr only.
  - Requests arriving during GAP are eligible in that GAP.
  - An owner re-requesting at release loses to any other requester but wins if alone (after GAP).
  - Min visible time per owner = HOLD_CYCLES cycles of grant.
  - Timer width = clog2(HOLD_CYCLES).
  - No state is entered with grant not one-hot/zero.

Test Plan (HOLD_CYCLES=4, NREQ=4):
1. Reset, then req=0 for 10 cycles -> seg_out=8'b00000010, grant=0, busy=0, switch_cnt=0.
2. req=0001, seg_in[0]=8'hC1 at t -> at t+1 grant=0001, seg_out=8'hC1, busy=1, switch_cnt=1. Holding req keeps grant for 20 cycles with no GAP.
3. req=1111 from IDLE, held -> grant sequence 0001,0010,0100,1000,0001. Each grant lasts 4 cycles, separated by one cycle of grant=0, seg_out=8'h00. switch_cnt=5.
4. Owner 2 drops req after 1 cycle of SHOW -> seg_out frozen at last pattern until 4 cycles elapse -> GAP -> IDLE shows 8'b00000010.
5. ena low for 6 cycles mid-SHOW (timer=2) -> outputs unchanged. After ena returns, release occurs exactly 2 cycles later.
6. rst_n low for 1 cycle mid-SHOW -> next edge grant=0, seg_out=8'b00000010, switch_cnt=0. Then req=0010 -> grant=0010 (rr_ptr back to 0).
